// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_ctrl
//  Purpose  : Memory-mapped GPIO bridge for DIP switches, user keys and LEDs.
//             Inputs are synchronised and debounced. Key presses latch sticky
//             edge flags that can raise a level interrupt.
//  Options  : GPIO_IRQ_EN - adds the EDGE/IRQEN registers and the irq output.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7F60,
    parameter int          SW_BYTES     = 8,
    parameter int          KEY_W        = 8,
    parameter int          LED_W        = 32,
    parameter int          DEBOUNCE_CYC = 500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             Address,
    input  logic [31:0]             WD,
    input  logic [3:0]              WE,
    input  logic [8*SW_BYTES-1:0]   dip_switch,
    input  logic [KEY_W-1:0]        user_key,
    output logic [31:0]             RD,
    output logic [LED_W-1:0]        led_light,
    output logic                    irq
);

    localparam int                c_SW_W    = 8 * SW_BYTES;
    localparam int                c_IN_W    = c_SW_W + KEY_W;
    localparam int                c_PW      = $clog2(DEBOUNCE_CYC);
    localparam logic [c_PW-1:0]   c_TICK_AT = c_PW'(DEBOUNCE_CYC - 1);

    localparam logic [2:0] c_OFF_SW_LO = 3'd0;
    localparam logic [2:0] c_OFF_SW_HI = 3'd1;
    localparam logic [2:0] c_OFF_KEY   = 3'd2;
    localparam logic [2:0] c_OFF_LED   = 3'd3;
    localparam logic [2:0] c_OFF_EDGE  = 3'd4;
    localparam logic [2:0] c_OFF_IRQEN = 3'd5;

    logic [c_PW-1:0]     r_presc;
    logic                w_tick;
    logic [c_IN_W-1:0]   w_raw;
    logic [c_IN_W-1:0]   r_sync1;
    logic [c_IN_W-1:0]   r_sync2;
    logic [c_IN_W-1:0]   r_sample;
    logic [c_IN_W-1:0]   r_deb;
    logic [c_IN_W-1:0]   w_deb_next;
    logic [c_SW_W-1:0]   w_sw_n;
    logic [KEY_W-1:0]    w_key_n;
    logic [63:0]         w_sw64;
    logic [31:0]         w_key_rd;
    logic [31:0]         w_led_rd;
    logic [31:0]         w_edge_rd;
    logic [31:0]         w_irqen_rd;
    logic [LED_W-1:0]    r_led;
    logic                w_sel;
    logic                w_wr;
    logic [2:0]          w_off;
    logic                w_wr_led;
    logic [31:0]         w_wmask;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Shared debounce prescaler: one-cycle tick when the count wraps
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_TICK_AT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser then two-sample debounce
    // ------------------------------------------------------------------
    assign w_raw = {user_key, dip_switch};

    // Debounced bit follows the sample only when two consecutive samples agree
    always_comb begin
        w_deb_next = r_deb;
        if (w_tick) begin
            w_deb_next = ((r_sync2 ~^ r_sample) & r_sample) |
                         ((r_sync2 ^ r_sample) & r_deb);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_sample <= '1;
            r_deb    <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_next;
            if (w_tick) begin
                r_sample <= r_sync2;
            end
        end
    end

    assign w_sw_n   = ~r_deb[c_SW_W-1:0];
    assign w_key_n  = ~r_deb[c_IN_W-1:c_SW_W];
    assign w_sw64   = 64'(w_sw_n);
    assign w_key_rd = 32'(w_key_n);

    // ------------------------------------------------------------------
    // Bus decode and byte-enabled writes
    // ------------------------------------------------------------------
    assign w_sel    = (Address[31:5] == BASE_ADDR[31:5]);
    assign w_wr     = w_sel && (WE != 4'b0000);
    assign w_off    = Address[4:2];
    assign w_wr_led = w_wr && (w_off == c_OFF_LED);
    assign w_wmask  = {{8{WE[3]}}, {8{WE[2]}}, {8{WE[1]}}, {8{WE[0]}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= '1;
        end else if (w_wr_led) begin
            r_led <= (r_led & ~w_wmask[LED_W-1:0]) |
                     (WD[LED_W-1:0] & w_wmask[LED_W-1:0]);
        end
    end

    assign w_led_rd  = 32'(r_led);
    assign led_light = ~r_led;

`ifdef GPIO_IRQ_EN
    // ------------------------------------------------------------------
    // Sticky press flags (W1C, set wins) and per-key interrupt enables
    // ------------------------------------------------------------------
    logic [KEY_W-1:0] r_edge;
    logic [KEY_W-1:0] r_irq_en;
    logic [KEY_W-1:0] w_press;
    logic [KEY_W-1:0] w_clr;
    logic             w_wr_edge;
    logic             w_wr_irqen;

    assign w_wr_edge  = w_wr && (w_off == c_OFF_EDGE);
    assign w_wr_irqen = w_wr && (w_off == c_OFF_IRQEN);
    assign w_press    = r_deb[c_IN_W-1:c_SW_W] & ~w_deb_next[c_IN_W-1:c_SW_W];
    assign w_clr      = w_wr_edge ? (WD[KEY_W-1:0] & w_wmask[KEY_W-1:0]) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_edge   <= '0;
            r_irq_en <= '0;
        end else begin
            r_edge <= w_press | (r_edge & ~w_clr);
            if (w_wr_irqen) begin
                r_irq_en <= (r_irq_en & ~w_wmask[KEY_W-1:0]) |
                            (WD[KEY_W-1:0] & w_wmask[KEY_W-1:0]);
            end
        end
    end

    assign irq        = |(r_edge & r_irq_en);
    assign w_edge_rd  = 32'(r_edge);
    assign w_irqen_rd = 32'(r_irq_en);
`else
    assign irq        = 1'b0;
    assign w_edge_rd  = '0;
    assign w_irqen_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux: purely a function of Address and register state
    // ------------------------------------------------------------------
    always_comb begin
        RD = '0;
        if (w_sel) begin
            case (w_off)
                c_OFF_SW_LO: RD = w_sw64[31:0];
                c_OFF_SW_HI: RD = w_sw64[63:32];
                c_OFF_KEY:   RD = w_key_rd;
                c_OFF_LED:   RD = w_led_rd;
                c_OFF_EDGE:  RD = w_edge_rd;
                c_OFF_IRQEN: RD = w_irqen_rd;
                default:     RD = '0;
            endcase
        end
    end

    assign w_unused = ^{Address[1:0], WD, w_wmask};

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_ctrl
//  Purpose  : Self-checking bench for gpio_ctrl (DEBOUNCE_CYC=4) with a
//             register-level reference model and randomised input patterns.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;

    localparam logic [31:0] c_BASE   = 32'h0000_7F60;
    localparam int          c_SETTLE = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WD;
    logic [3:0]  WE;
    logic [63:0] dip_switch;
    logic [7:0]  user_key;
    logic [31:0] RD;
    logic [31:0] led_light;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_led;
    logic [7:0]  m_edge;
    logic [7:0]  m_en;

    logic [31:0] rdata;
    logic [31:0] rnd_d;
    logic [3:0]  rnd_we;
    logic [7:0]  new_key;
    logic [7:0]  rnd_c;
    logic        seen;

    gpio_ctrl #(
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WD         (WD),
        .WE         (WE),
        .dip_switch (dip_switch),
        .user_key   (user_key),
        .RD         (RD),
        .led_light  (led_light),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        @(negedge clk);
        Address = c_BASE + 32'(off * 4);
        #1 d = RD;
    endtask

    task automatic rd_chk(input string tag, input int off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] we);
        @(negedge clk);
        Address = c_BASE + 32'(off * 4);
        WD      = d;
        WE      = we;
        @(posedge clk);
        #1 WE = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] led_apply(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] we);
        led_apply = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) led_apply[8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] irq_en_read(input logic [7:0] en);
`ifdef GPIO_IRQ_EN
        irq_en_read = {24'b0, en};
`else
        irq_en_read = 32'h0 & {24'b0, en};
`endif
    endfunction

    initial begin
        reset      = 1'b0;
        Address    = '0;
        WD         = '0;
        WE         = '0;
        dip_switch = '1;
        user_key   = '1;
        m_led      = 32'hFFFF_FFFF;
        m_edge     = '0;
        m_en       = '0;
        seen       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rd_chk("rst_sw_lo", 0, 32'h0);
        rd_chk("rst_sw_hi", 1, 32'h0);
        rd_chk("rst_key",   2, 32'h0);
        rd_chk("rst_led",   3, 32'hFFFF_FFFF);
        rd_chk("rst_edge",  4, 32'h0);
        rd_chk("rst_irqen", 5, 32'h0);
        check("rst_led_light", led_light, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Byte-enabled LED write
        wr(3, 32'h1234_5678, 4'b0101);
        m_led = led_apply(m_led, 32'h1234_5678, 4'b0101);
        rd_chk("led_be", 3, 32'hFF34_FF78);
        check("led_light_be", led_light, 32'h00CB_0087);
        wr(3, 32'hDEAD_BEEF, 4'b0000);
        rd_chk("led_we0", 3, m_led);
        wr(8, 32'h0, 4'b1111);
        rd_chk("led_outside_window", 3, m_led);

        // Switch debounce and glitch rejection
        @(negedge clk);
        dip_switch[7:0] = 8'hFE;
        idle(c_SETTLE);
        rd_chk("sw_bank0", 0, 32'h0000_0001);
        @(negedge clk);
        dip_switch[15:8] = 8'h00;
        idle(3);
        dip_switch[15:8] = 8'hFF;
        idle(c_SETTLE);
        rd_chk("sw_glitch", 0, 32'h0000_0001);
        rd_chk("sw_hi_idle", 1, 32'h0);

        // Key press, edge flag, interrupt, W1C
        wr(5, 32'h1, 4'b0001);
        m_en = 8'h01;
        rd_chk("irqen_wr", 5, irq_en_read(m_en));
        @(negedge clk);
        user_key[0] = 1'b0;
        idle(c_SETTLE);
        rd_chk("key0_press", 2, 32'h1);
`ifdef GPIO_IRQ_EN
        rd_chk("edge_set", 4, 32'h1);
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(4, 32'h1, 4'b0001);
        rd_chk("edge_w1c", 4, 32'h0);
        check("irq_clr", {31'b0, irq}, 32'h0);
        idle(c_SETTLE);
        rd_chk("edge_hold", 4, 32'h0);
        @(negedge clk);
        user_key[0] = 1'b1;
        idle(c_SETTLE);
        rd_chk("edge_release", 4, 32'h0);

        // Clear and set on the same edge: set must win
        @(negedge clk);
        user_key[0] = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            Address = c_BASE + 32'd16;
            WD      = 32'h1;
            WE      = 4'b0001;
            #1 seen = RD[0];
        end
        WE = 4'b0000;
        check("set_wins_seen", {31'b0, seen}, 32'h1);
        idle(2);
        rd_chk("set_wins_kept", 4, 32'h1);
        wr(4, 32'h1, 4'b0001);
        @(negedge clk);
        user_key[0] = 1'b1;
        idle(c_SETTLE);
`else
        rd_chk("edge_disabled", 4, 32'h0);
        check("irq_disabled", {31'b0, irq}, 32'h0);
        @(negedge clk);
        user_key[0] = 1'b1;
        idle(c_SETTLE);
`endif

        // Randomised input patterns against the register-level model
        for (int it = 0; it < 12; it++) begin
            new_key = 8'($urandom);
            @(negedge clk);
            m_edge     = m_edge | (user_key & ~new_key);
            user_key   = new_key;
            dip_switch = {$urandom, $urandom};
            idle(c_SETTLE);
            rd_chk("rnd_sw_lo", 0, ~dip_switch[31:0]);
            rd_chk("rnd_sw_hi", 1, ~dip_switch[63:32]);
            rd_chk("rnd_key",   2, {24'b0, ~user_key});

            rnd_d  = $urandom;
            rnd_we = 4'($urandom);
            wr(3, rnd_d, rnd_we);
            m_led = led_apply(m_led, rnd_d, rnd_we);
            rd_chk("rnd_led", 3, m_led);
            check("rnd_led_light", led_light, ~m_led);
`ifdef GPIO_IRQ_EN
            rnd_d = $urandom;
            wr(5, rnd_d, 4'b1111);
            m_en = rnd_d[7:0];
            rd_chk("rnd_irqen", 5, {24'b0, m_en});
            rd_chk("rnd_edge", 4, {24'b0, m_edge});
            check("rnd_irq", {31'b0, irq}, {31'b0, |(m_edge & m_en)});
            rnd_c  = 8'($urandom);
            rnd_we = 4'($urandom);
            wr(4, {24'hFF_FFFF, rnd_c}, rnd_we);
            if (rnd_we[0]) m_edge = m_edge & ~rnd_c;
            rd_chk("rnd_edge_w1c", 4, {24'b0, m_edge});
            check("rnd_irq_w1c", {31'b0, irq}, {31'b0, |(m_edge & m_en)});
`else
            rd_chk("rnd_edge_off", 4, 32'h0);
            check("rnd_irq_off", {31'b0, irq}, 32'h0);
`endif
        end

        // Reset asserted while a press is still being debounced
        @(negedge clk);
        user_key   = '1;
        dip_switch = '1;
        idle(c_SETTLE);
        wr(4, 32'hFF, 4'b0001);
        wr(3, 32'h0, 4'b1111);
        @(negedge clk);
        user_key[0] = 1'b0;
        idle(5);
        #2 reset = 1'b0;
        Address = c_BASE + 32'd12;
        #1;
        check("midrst_led", RD, 32'hFFFF_FFFF);
        check("midrst_led_light", led_light, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        Address = c_BASE + 32'd8;
        #1;
        check("midrst_key", RD, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(c_SETTLE);
        rd_chk("reacq_key", 2, 32'h1);
        rd_chk("reacq_irqen", 5, 32'h0);
`ifdef GPIO_IRQ_EN
        rd_chk("reacq_edge", 4, 32'h1);
        wr(4, 32'h1, 4'b0001);
        idle(c_SETTLE);
        rd_chk("reacq_edge_once", 4, 32'h0);
`else
        rd_chk("reacq_edge_off", 4, 32'h0);
        check("reacq_irq_off", {31'b0, irq}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
